// File: rtl/mod_id.sv
// mod_id: single-cycle instruction decode stage.
// Decodes the 16-bit instruction into datapath controls, forms the immediate,
// resolves branches against the {Z,V,N} flags to produce the next pc, and
// holds the 16x16 register file. Register 0 is hard-wired to zero. A write in
// flight is forwarded to the read ports in the same cycle.
module mod_id (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    input  logic [15:0] pc,
    input  logic [2:0]  flag,
    input  logic [15:0] DstData,
    output logic        regwrite,
    output logic        alusrc,
    output logic        memenable,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        alusext,
    output logic        pcread,
    output logic        rdsrc,
    output logic [1:0]  branch,
    output logic [3:0]  aluop,
    output logic [3:0]  SrcReg1,
    output logic [3:0]  SrcReg2,
    output logic [15:0] SrcData1,
    output logic [15:0] SrcData2,
    output logic [15:0] new_pc,
    output logic [15:0] imm_16bit
);

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_IMM  = 2'b01;
    localparam logic [1:0] BR_REG  = 2'b10;

    logic [3:0]  opcode;
    logic [3:0]  wr_addr;
    logic [2:0]  ccc;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        cond_met;
    logic        wr_en;
    logic [15:0] pc_plus2;
    logic [15:0] regs_q [16];
    logic [15:0] regs_d [16];

    assign opcode  = instruction[15:12];
    assign wr_addr = instruction[11:8];
    assign ccc     = instruction[11:9];
    assign flag_z  = flag[2];
    assign flag_v  = flag[1];
    assign flag_n  = flag[0];

    // Control decode: every control output is a pure function of the opcode.
    always_comb begin
        regwrite  = 1'b0;
        alusrc    = 1'b0;
        memenable = 1'b0;
        memwrite  = 1'b0;
        memtoreg  = 1'b0;
        alusext   = 1'b0;
        pcread    = 1'b0;
        rdsrc     = 1'b0;
        branch    = BR_NONE;
        aluop     = 4'h0;
        case (opcode)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                regwrite = 1'b1;
                aluop    = opcode;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                aluop    = opcode;
            end
            OP_LW: begin
                regwrite  = 1'b1;
                alusrc    = 1'b1;
                memenable = 1'b1;
                memtoreg  = 1'b1;
                alusext   = 1'b1;
            end
            OP_SW: begin
                alusrc    = 1'b1;
                memenable = 1'b1;
                memwrite  = 1'b1;
                alusext   = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                rdsrc    = 1'b1;
                aluop    = opcode;
            end
            OP_B: begin
                branch = BR_IMM;
            end
            OP_BR: begin
                branch = BR_REG;
            end
            OP_PCS: begin
                regwrite = 1'b1;
                pcread   = 1'b1;
            end
            default: begin
                // HLT: everything idle
            end
        endcase
    end

    // Register-read addresses: LLB/LHB read their own destination, SW reads the store data from rd.
    always_comb begin
        SrcReg1 = rdsrc ? instruction[11:8] : instruction[7:4];
        SrcReg2 = (opcode == OP_SW) ? instruction[11:8] : instruction[3:0];
    end

    // Immediate formation; memory and branch offsets are halfword offsets, hence the shift.
    always_comb begin
        imm_16bit = 16'h0000;
        case (opcode)
            OP_SLL, OP_SRA, OP_ROR:
                imm_16bit = {12'h000, instruction[3:0]};
            OP_LW, OP_SW:
                imm_16bit = {{11{instruction[3]}}, instruction[3:0], 1'b0};
            OP_LLB, OP_LHB:
                imm_16bit = {8'h00, instruction[7:0]};
            OP_B:
                imm_16bit = {{6{instruction[8]}}, instruction[8:0], 1'b0};
            default:
                imm_16bit = 16'h0000;
        endcase
    end

    // Branch condition evaluation against the {Z,V,N} flags.
    always_comb begin
        cond_met = 1'b0;
        case (ccc)
            3'b000: cond_met = ~flag_z;
            3'b001: cond_met = flag_z;
            3'b010: cond_met = ~flag_z & ~flag_n;
            3'b011: cond_met = flag_n;
            3'b100: cond_met = flag_z | (~flag_z & ~flag_n);
            3'b101: cond_met = flag_n | flag_z;
            3'b110: cond_met = flag_v;
            default: cond_met = 1'b1;
        endcase
    end

    // Next-pc selection; all additions wrap at 16 bits.
    always_comb begin
        pc_plus2 = pc + 16'd2;
        new_pc   = pc_plus2;
        case (opcode)
            OP_B:    new_pc = cond_met ? (pc_plus2 + imm_16bit) : pc_plus2;
            OP_BR:   new_pc = cond_met ? SrcData1 : pc_plus2;
            OP_HLT:  new_pc = pc;
            default: new_pc = pc_plus2;
        endcase
    end

    // Write qualification: R0 is never written and reset blocks all writes.
    always_comb begin
        wr_en = regwrite & rst & (wr_addr != 4'h0);
    end

    // Register-file next state: only the addressed entry takes DstData.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_addr == 4'(i))) begin
                regs_d[i] = DstData;
            end
        end
        regs_d[0] = 16'h0000;
    end

    // Register-file storage, cleared and held at zero while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports with same-cycle forwarding of the pending write.
    always_comb begin
        if (SrcReg1 == 4'h0) begin
            SrcData1 = 16'h0000;
        end else if (wr_en && (wr_addr == SrcReg1)) begin
            SrcData1 = DstData;
        end else begin
            SrcData1 = regs_q[SrcReg1];
        end

        if (SrcReg2 == 4'h0) begin
            SrcData2 = 16'h0000;
        end else if (wr_en && (wr_addr == SrcReg2)) begin
            SrcData2 = DstData;
        end else begin
            SrcData2 = regs_q[SrcReg2];
        end
    end

endmodule

// File: tb/tb_mod_id.sv
// Directed bench for mod_id: each step drives inputs, queues the expected
// outputs, then pops and compares them once the combinational outputs settle.
module tb_mod_id;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic [2:0]  flag;
    logic [15:0] DstData;
    logic        regwrite, alusrc, memenable, memwrite, memtoreg, alusext, pcread, rdsrc;
    logic [1:0]  branch;
    logic [3:0]  aluop;
    logic [3:0]  SrcReg1, SrcReg2;
    logic [15:0] SrcData1, SrcData2, new_pc, imm_16bit;

    int tests_run = 0;
    int tests_failed = 0;

    typedef enum int {
        F_RW, F_ALUSRC, F_MEMEN, F_MEMWR, F_MEMTOREG, F_ALUSEXT, F_PCREAD, F_RDSRC,
        F_BRANCH, F_ALUOP, F_SR1, F_SR2, F_SD1, F_SD2, F_NPC, F_IMM
    } field_e;

    typedef struct {
        string       tag;
        field_e      f;
        logic [15:0] v;
    } exp_t;

    exp_t sb[$];

    mod_id dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .flag(flag),
        .DstData(DstData), .regwrite(regwrite), .alusrc(alusrc), .memenable(memenable),
        .memwrite(memwrite), .memtoreg(memtoreg), .alusext(alusext), .pcread(pcread),
        .rdsrc(rdsrc), .branch(branch), .aluop(aluop), .SrcReg1(SrcReg1),
        .SrcReg2(SrcReg2), .SrcData1(SrcData1), .SrcData2(SrcData2),
        .new_pc(new_pc), .imm_16bit(imm_16bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] obs(field_e f);
        case (f)
            F_RW:       return {15'h0, regwrite};
            F_ALUSRC:   return {15'h0, alusrc};
            F_MEMEN:    return {15'h0, memenable};
            F_MEMWR:    return {15'h0, memwrite};
            F_MEMTOREG: return {15'h0, memtoreg};
            F_ALUSEXT:  return {15'h0, alusext};
            F_PCREAD:   return {15'h0, pcread};
            F_RDSRC:    return {15'h0, rdsrc};
            F_BRANCH:   return {14'h0, branch};
            F_ALUOP:    return {12'h0, aluop};
            F_SR1:      return {12'h0, SrcReg1};
            F_SR2:      return {12'h0, SrcReg2};
            F_SD1:      return SrcData1;
            F_SD2:      return SrcData2;
            F_NPC:      return new_pc;
            default:    return imm_16bit;
        endcase
    endfunction

    task automatic push(input string tag, input field_e f, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.f   = f;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.f);
            tests_run++;
            assert (o === e.v)
            else begin
                tests_failed++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic step(input logic [15:0] ins, input logic [15:0] p, input logic [2:0] fl,
                        input logic [15:0] dd);
        @(negedge clk);
        instruction = ins;
        pc          = p;
        flag        = fl;
        DstData     = dd;
    endtask

    initial begin
        rst = 1'b0;
        instruction = 16'h0000;
        pc = 16'h0000;
        flag = 3'b000;
        DstData = 16'h0000;

        // Reset-time decode
        step(16'h0000, 16'h0000, 3'b000, 16'h0000);
        push("rst_regwrite", F_RW, 16'h1);
        push("rst_alusrc", F_ALUSRC, 16'h0);
        push("rst_aluop", F_ALUOP, 16'h0);
        push("rst_branch", F_BRANCH, 16'h0);
        push("rst_sr1", F_SR1, 16'h0);
        push("rst_sr2", F_SR2, 16'h0);
        push("rst_sd1", F_SD1, 16'h0000);
        push("rst_sd2", F_SD2, 16'h0000);
        push("rst_npc", F_NPC, 16'h0002);
        push("rst_imm", F_IMM, 16'h0000);
        drain();

        // Write attempt during reset must be blocked, and is not forwarded
        step(16'hA305, 16'h0000, 3'b000, 16'h1234);
        push("rst_llb_sd1", F_SD1, 16'h0000);
        push("rst_llb_imm", F_IMM, 16'h0005);
        drain();
        step(16'h0030, 16'h0000, 3'b000, 16'h0000);
        push("rst_hold_r3", F_SD1, 16'h0000);
        drain();

        rst = 1'b1;

        step(16'h4000, 16'h0000, 3'b000, 16'h0000);
        push("sll_regwrite", F_RW, 16'h1);
        push("sll_alusrc", F_ALUSRC, 16'h1);
        push("sll_aluop", F_ALUOP, 16'h4);
        push("sll_memen", F_MEMEN, 16'h0);
        push("sll_imm", F_IMM, 16'h0000);
        push("sll_npc", F_NPC, 16'h0002);
        drain();

        step(16'h6007, 16'h0010, 3'b000, 16'h0000);
        push("ror_imm", F_IMM, 16'h0007);
        push("ror_aluop", F_ALUOP, 16'h6);
        push("ror_npc", F_NPC, 16'h0012);
        drain();

        step(16'h8000, 16'h0000, 3'b000, 16'h0000);
        push("lw_memen", F_MEMEN, 16'h1);
        push("lw_memwr", F_MEMWR, 16'h0);
        push("lw_memtoreg", F_MEMTOREG, 16'h1);
        push("lw_alusext", F_ALUSEXT, 16'h1);
        push("lw_alusrc", F_ALUSRC, 16'h1);
        push("lw_aluop", F_ALUOP, 16'h0);
        push("lw_regwrite", F_RW, 16'h1);
        drain();

        step(16'h800F, 16'h0000, 3'b000, 16'h0000);
        push("lw_imm_neg", F_IMM, 16'hFFFE);
        drain();

        step(16'h9A37, 16'h0000, 3'b000, 16'h0000);
        push("sw_memwr", F_MEMWR, 16'h1);
        push("sw_memtoreg", F_MEMTOREG, 16'h0);
        push("sw_regwrite", F_RW, 16'h0);
        push("sw_sr2", F_SR2, 16'hA);
        push("sw_sr1", F_SR1, 16'h3);
        push("sw_imm", F_IMM, 16'h000E);
        drain();

        // LLB R3 writes at the coming edge; same-cycle forwarding visible now
        step(16'hA305, 16'h0000, 3'b000, 16'h1234);
        push("llb_rdsrc", F_RDSRC, 16'h1);
        push("llb_sr1", F_SR1, 16'h3);
        push("llb_aluop", F_ALUOP, 16'hA);
        push("llb_bypass", F_SD1, 16'h1234);
        drain();

        step(16'h0030, 16'h0000, 3'b000, 16'h0000);
        push("add_sr1_rs", F_SR1, 16'h3);
        push("r3_via_sr1", F_SD1, 16'h1234);
        drain();

        step(16'h0003, 16'h0000, 3'b000, 16'h0000);
        push("add_sr1_zero", F_SR1, 16'h0);
        push("add_sr2", F_SR2, 16'h3);
        push("r3_via_sr2", F_SD2, 16'h1234);
        drain();

        // Write to R0 is discarded
        step(16'hA0FF, 16'h0000, 3'b000, 16'hBEEF);
        push("r0_no_bypass", F_SD1, 16'h0000);
        drain();
        step(16'hB000, 16'h0000, 3'b000, 16'h0000);
        push("r0_reads_zero", F_SD1, 16'h0000);
        push("lhb_aluop", F_ALUOP, 16'hB);
        drain();

        // Load R5 = 8000 for BR tests
        step(16'hB580, 16'h0000, 3'b000, 16'h8000);
        push("lhb_imm", F_IMM, 16'h0080);
        drain();

        step(16'hD050, 16'h0040, 3'b000, 16'h0000);
        push("br_branch", F_BRANCH, 16'h2);
        push("br_regwrite", F_RW, 16'h0);
        push("br_taken", F_NPC, 16'h8000);
        drain();
        step(16'hD050, 16'h0040, 3'b100, 16'h0000);
        push("br_not_taken", F_NPC, 16'h0042);
        drain();

        // PC-relative branches
        step(16'hC000, 16'h0000, 3'b000, 16'h0000);
        push("b_branch", F_BRANCH, 16'h1);
        push("b_regwrite", F_RW, 16'h0);
        push("b_imm_zero", F_IMM, 16'h0000);
        push("b_npc_zero_off", F_NPC, 16'h0002);
        drain();

        step(16'hC1FF, 16'h0100, 3'b000, 16'h0000);
        push("b_imm_m2", F_IMM, 16'hFFFE);
        push("b_npc_self", F_NPC, 16'h0100);
        drain();

        step(16'hC2FF, 16'h0100, 3'b000, 16'h0000);
        push("b_eq_not_taken", F_NPC, 16'h0102);
        drain();
        step(16'hC2FF, 16'h0100, 3'b100, 16'h0000);
        push("b_eq_taken", F_NPC, 16'h0300);
        drain();

        step(16'hC410, 16'h0100, 3'b001, 16'h0000);
        push("b_gt_n_set", F_NPC, 16'h0102);
        drain();
        step(16'hC610, 16'h0100, 3'b001, 16'h0000);
        push("b_lt_taken", F_NPC, 16'h0122);
        drain();
        step(16'hC810, 16'h0100, 3'b001, 16'h0000);
        push("b_ge_n_set", F_NPC, 16'h0102);
        drain();
        step(16'hCA10, 16'h0100, 3'b100, 16'h0000);
        push("b_le_z_set", F_NPC, 16'h0122);
        drain();
        step(16'hCC04, 16'h0100, 3'b010, 16'h0000);
        push("b_ovf_taken", F_NPC, 16'h010A);
        drain();
        step(16'hCC04, 16'h0100, 3'b101, 16'h0000);
        push("b_ovf_not_taken", F_NPC, 16'h0102);
        drain();
        step(16'hCE10, 16'h0100, 3'b111, 16'h0000);
        push("b_always", F_NPC, 16'h0122);
        drain();

        step(16'h0000, 16'hFFFE, 3'b000, 16'h0000);
        push("pc_wrap", F_NPC, 16'h0000);
        drain();

        step(16'hF000, 16'h0200, 3'b000, 16'h0000);
        push("hlt_npc", F_NPC, 16'h0200);
        push("hlt_regwrite", F_RW, 16'h0);
        drain();

        step(16'hE500, 16'h0200, 3'b000, 16'h0000);
        push("pcs_pcread", F_PCREAD, 16'h1);
        push("pcs_regwrite", F_RW, 16'h1);
        push("pcs_npc", F_NPC, 16'h0202);
        drain();

        // Asynchronous clear between clock edges
        step(16'h0003, 16'h0000, 3'b000, 16'h0000);
        push("pre_async_r3", F_SD2, 16'h1234);
        drain();
        #1;
        rst = 1'b0;
        push("async_clear_r3", F_SD2, 16'h0000);
        push("async_npc_valid", F_NPC, 16'h0002);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
